// File: rtl/lcd_watch_chargen.sv
// BCD 24-hour watch with alarm, two debounced push buttons and a registered
// character generator serving a 2x16 LCD driver by character address.
module lcd_watch_chargen #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       BTN_SOUTH,
    input  logic       BTN_EAST,
    input  logic [3:0] SW,
    input  logic [7:0] LcdIndex,
    output logic [7:0] LcdChar,
    output logic [7:0] sec_digits,
    output logic [7:0] min_digits,
    output logic [7:0] hrs_digits,
    output logic       ALARM,
    output logic [7:0] LED
);
    localparam int PW = $clog2(CLK_HZ);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);
    localparam logic [DW-1:0] DEB_MAX    = DW'(DEB_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_SET_HRS  = 3'd1,
        ST_SET_MIN  = 3'd2,
        ST_SET_AHRS = 3'd3,
        ST_SET_AMIN = 3'd4
    } state_t;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
        if (v == top)           return 8'h00;
        else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        else                    return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] dig(input logic [3:0] n);
        return {4'b0011, n};
    endfunction

    state_t     r_state, w_state_next;
    logic [1:0] w_btn_raw, w_btn_pulse;
    logic       w_east, w_south, w_ack, w_presc_run, w_tick, w_alarm_hit;
    logic       w_inc_hrs, w_inc_min, w_inc_ahrs, w_inc_amin;
    logic [3:0] w_blank;
    logic [PW-1:0] r_presc, r_blink_cnt;
    logic       r_blink, r_alarm;
    logic [7:0] r_sec, r_min, r_hrs, r_ahrs, r_amin;
    logic [7:0] w_sec_tick, w_min_tick, w_hrs_tick;
    logic [4:0] w_hrs_bin, w_h12;
    logic       w_pm;
    logic [7:0] w_hrs_disp, w_char, r_lcd_char;
    logic       w_unused_sw;

    assign w_unused_sw = SW[3];
    assign w_btn_raw   = {BTN_EAST, BTN_SOUTH};

    // Index 0 = south, 1 = east: synchroniser, debouncer, rising-edge pulse.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic          r_meta, r_sync, r_level, r_level_d;
            logic [DW-1:0] r_cnt;
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    r_meta    <= 1'b0;
                    r_sync    <= 1'b0;
                    r_level   <= 1'b0;
                    r_level_d <= 1'b0;
                    r_cnt     <= '0;
                end else begin
                    r_meta    <= w_btn_raw[gi];
                    r_sync    <= r_meta;
                    r_level_d <= r_level;
                    if (r_sync == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == DEB_MAX) begin
                        r_level <= r_sync;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + DW'(1);
                    end
                end
            end
            assign w_btn_pulse[gi] = r_level & ~r_level_d;
        end
    endgenerate

    // East has priority; a coincident south pulse is discarded.
    assign w_east  = w_btn_pulse[1];
    assign w_south = w_btn_pulse[0] & ~w_btn_pulse[1];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= ST_RUN;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_east) begin
            case (r_state)
                ST_RUN:      w_state_next = ST_SET_HRS;
                ST_SET_HRS:  w_state_next = ST_SET_MIN;
                ST_SET_MIN:  w_state_next = ST_SET_AHRS;
                ST_SET_AHRS: w_state_next = ST_SET_AMIN;
                default:     w_state_next = ST_RUN;
            endcase
        end
    end

    always_comb begin
        w_presc_run = 1'b1;
        w_ack       = 1'b0;
        w_inc_hrs   = 1'b0;
        w_inc_min   = 1'b0;
        w_inc_ahrs  = 1'b0;
        w_inc_amin  = 1'b0;
        w_blank     = 4'b0000;
        case (r_state)
            ST_RUN:      w_ack = w_south;
            ST_SET_HRS:  begin w_presc_run = 1'b0; w_inc_hrs = w_south; w_blank[0] = ~r_blink; end
            ST_SET_MIN:  begin w_presc_run = 1'b0; w_inc_min = w_south; w_blank[1] = ~r_blink; end
            ST_SET_AHRS: begin w_inc_ahrs = w_south; w_blank[2] = ~r_blink; end
            ST_SET_AMIN: begin w_inc_amin = w_south; w_blank[3] = ~r_blink; end
            default:     w_ack = 1'b0;
        endcase
        if (SW[2]) w_presc_run = 1'b0;
    end

    assign w_tick = w_presc_run && (r_presc == PRESC_MAX);

    // Blink runs off its own free counter so edited fields still flash while
    // the seconds prescaler is frozen.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_presc     <= '0;
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else begin
            if (w_inc_min)        r_presc <= '0;
            else if (w_presc_run) r_presc <= (r_presc == PRESC_MAX) ? '0 : r_presc + PW'(1);
            r_blink_cnt <= (r_blink_cnt == PRESC_MAX) ? '0 : r_blink_cnt + PW'(1);
            if (r_blink_cnt == PRESC_HALF || r_blink_cnt == PRESC_MAX) r_blink <= ~r_blink;
        end
    end

    assign w_sec_tick  = bcd_inc(r_sec, 8'h59);
    assign w_min_tick  = (r_sec == 8'h59) ? bcd_inc(r_min, 8'h59) : r_min;
    assign w_hrs_tick  = (r_sec == 8'h59 && r_min == 8'h59) ? bcd_inc(r_hrs, 8'h23) : r_hrs;
    assign w_alarm_hit = w_tick && SW[1] && (r_sec == 8'h59) &&
                         (w_min_tick == r_amin) && (w_hrs_tick == r_ahrs);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sec   <= 8'h00;
            r_min   <= 8'h00;
            r_hrs   <= 8'h00;
            r_ahrs  <= 8'h07;
            r_amin  <= 8'h00;
            r_alarm <= 1'b0;
        end else begin
            if (w_tick) begin
                r_sec <= w_sec_tick;
                r_min <= w_min_tick;
                r_hrs <= w_hrs_tick;
            end
            if (w_inc_hrs)  r_hrs <= bcd_inc(r_hrs, 8'h23);
            if (w_inc_min) begin
                r_min <= bcd_inc(r_min, 8'h59);
                r_sec <= 8'h00;
            end
            if (w_inc_ahrs) r_ahrs <= bcd_inc(r_ahrs, 8'h23);
            if (w_inc_amin) r_amin <= bcd_inc(r_amin, 8'h59);
            if (!SW[1] || w_ack)  r_alarm <= 1'b0;
            else if (w_alarm_hit) r_alarm <= 1'b1;
        end
    end

    // 12-hour view: 0 -> 12 AM, 12 -> 12 PM, 13..23 -> 1..11 PM.
    always_comb begin
        w_hrs_bin = 5'(r_hrs[7:4]) * 5'd10 + 5'(r_hrs[3:0]);
        w_pm      = (w_hrs_bin >= 5'd12);
        w_h12     = w_pm ? (w_hrs_bin - 5'd12) : w_hrs_bin;
        if (w_h12 == 5'd0) w_h12 = 5'd12;
        if (!SW[0])               w_hrs_disp = r_hrs;
        else if (w_h12 >= 5'd10)  w_hrs_disp = {4'd1, 4'(w_h12 - 5'd10)};
        else                      w_hrs_disp = {4'd0, w_h12[3:0]};
    end

    always_comb begin
        w_char = 8'h20;
        case (LcdIndex)
            8'h00: w_char = "T";
            8'h01: w_char = "i";
            8'h02: w_char = "m";
            8'h03: w_char = "e";
            8'h04: w_char = "=";
            8'h06: w_char = w_blank[0] ? 8'h20 : dig(w_hrs_disp[7:4]);
            8'h07: w_char = w_blank[0] ? 8'h20 : dig(w_hrs_disp[3:0]);
            8'h08: w_char = ":";
            8'h09: w_char = w_blank[1] ? 8'h20 : dig(r_min[7:4]);
            8'h0A: w_char = w_blank[1] ? 8'h20 : dig(r_min[3:0]);
            8'h0B: w_char = ":";
            8'h0C: w_char = dig(r_sec[7:4]);
            8'h0D: w_char = dig(r_sec[3:0]);
            8'h0E: w_char = !SW[0] ? 8'h20 : (w_pm ? "P" : "A");
            8'h0F: w_char = SW[0] ? "M" : 8'h20;
            8'h40: w_char = "A";
            8'h41: w_char = "l";
            8'h42: w_char = "m";
            8'h44: w_char = w_blank[2] ? 8'h20 : dig(r_ahrs[7:4]);
            8'h45: w_char = w_blank[2] ? 8'h20 : dig(r_ahrs[3:0]);
            8'h46: w_char = ":";
            8'h47: w_char = w_blank[3] ? 8'h20 : dig(r_amin[7:4]);
            8'h48: w_char = w_blank[3] ? 8'h20 : dig(r_amin[3:0]);
            8'h4A: w_char = SW[1] ? "*" : 8'h20;
            8'h4F: w_char = {5'b00110, r_state};
            default: w_char = 8'h20;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_lcd_char <= 8'h00;
        else        r_lcd_char <= w_char;
    end

    assign LcdChar    = r_lcd_char;
    assign sec_digits = r_sec;
    assign min_digits = r_min;
    assign hrs_digits = r_hrs;
    assign ALARM      = r_alarm;
    assign LED        = {r_alarm, 4'b0000, r_state};
endmodule

// File: tb/tb_lcd_watch_chargen.sv
// Self-checking bench for lcd_watch_chargen with a short second (CLK_HZ=10)
// and fast debounce (DEB_CYCLES=4).
`timescale 1ns/1ps
module tb_lcd_watch_chargen;
    localparam int CLK_HZ     = 10;
    localparam int DEB_CYCLES = 4;

    typedef struct {
        logic [7:0] idx;
        logic [7:0] exp;
    } lcd_vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_south, btn_east;
    logic [3:0] sw;
    logic [7:0] lcd_index;
    logic [7:0] lcd_char, sec_d, min_d, hrs_d, led;
    logic       alarm;

    int n_tests = 0;
    int n_fail  = 0;
    lcd_vec_t   lcd_tab[$];
    logic [7:0] exp_q[$];
    logic [7:0] idx_q[$];

    lcd_watch_chargen #(.CLK_HZ(CLK_HZ), .DEB_CYCLES(DEB_CYCLES)) dut (
        .CLK(clk), .RST_N(rst_n), .BTN_SOUTH(btn_south), .BTN_EAST(btn_east),
        .SW(sw), .LcdIndex(lcd_index), .LcdChar(lcd_char),
        .sec_digits(sec_d), .min_digits(min_d), .hrs_digits(hrs_d),
        .ALARM(alarm), .LED(led)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, required normal finish");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end else begin
            $display("[TB] %s: 0x%02h ok", name, act);
        end
    endtask

    task automatic press(input logic s, input logic e);
        btn_south = s;
        btn_east  = e;
        cyc(8);
        btn_south = 1'b0;
        btn_east  = 1'b0;
        cyc(8);
    endtask

    task automatic east_to(input logic [2:0] st);
        press(1'b0, 1'b1);
        check8("state", {5'd0, led[2:0]}, {5'd0, st});
    endtask

    function automatic logic [7:0] cur_field(input int f);
        return (f == 0) ? hrs_d : min_d;
    endfunction

    // Presses south at least once, until the chosen field reaches target.
    task automatic press_until(input int f, input logic [7:0] target, input int bound, input string name);
        int k;
        k = 0;
        do begin
            press(1'b1, 1'b0);
            k++;
        end while (cur_field(f) != target && k < bound);
        n_tests++;
        if (cur_field(f) != target) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h within %0d presses", name, cur_field(f), target, bound);
        end else begin
            $display("[TB] %s: 0x%02h reached after %0d presses", name, target, k);
        end
    endtask

    task automatic wait_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                             input int bound, input string name);
        int k;
        for (k = 0; k < bound; k++) begin
            if (hrs_d == h && min_d == m && sec_d == s) break;
            cyc(1);
        end
        n_tests++;
        if (k >= bound) begin
            n_fail++;
            $display("FAIL %s: got %02h:%02h:%02h, expected %02h:%02h:%02h within %0d cycles",
                     name, hrs_d, min_d, sec_d, h, m, s, bound);
        end else begin
            $display("[TB] %s: %02h:%02h:%02h after %0d cycles", name, h, m, s, k);
        end
    endtask

    task automatic add_vec(input logic [7:0] i, input logic [7:0] e);
        lcd_vec_t v;
        v.idx = i;
        v.exp = e;
        lcd_tab.push_back(v);
    endtask

    // Each index is driven on one falling edge and its character is expected
    // exactly one rising edge later.
    task automatic run_lcd_tab();
        for (int k = 0; k < lcd_tab.size(); k++) begin
            lcd_index = lcd_tab[k].idx;
            exp_q.push_back(lcd_tab[k].exp);
            idx_q.push_back(lcd_tab[k].idx);
            cyc(1);
            check8($sformatf("lcd[%02h]", idx_q.pop_front()), lcd_char, exp_q.pop_front());
        end
        lcd_tab.delete();
    endtask

    initial begin
        int seen_blank, seen_digit, seen_other;
        rst_n = 1'b0; btn_south = 1'b0; btn_east = 1'b0; sw = 4'b0000; lcd_index = 8'h00;

        // Reset state and exact first tick.
        cyc(3);
        check8("rst_sec", sec_d, 8'h00);
        check8("rst_hrs", hrs_d, 8'h00);
        check8("rst_led", led, 8'h00);
        check8("rst_lcdchar", lcd_char, 8'h00);
        rst_n = 1'b1;
        cyc(9);
        check8("sec_before_first_tick", sec_d, 8'h00);
        cyc(1);
        check8("sec_first_tick", sec_d, 8'h01);
        cyc(590);
        check8("min_600", min_d, 8'h01);
        check8("sec_600", sec_d, 8'h00);
        add_vec(8'h0A, 8'h31); add_vec(8'h00, "T"); add_vec(8'h01, "i"); add_vec(8'h02, "m");
        add_vec(8'h03, "e");   add_vec(8'h04, "=");  add_vec(8'h05, " "); add_vec(8'h06, "0");
        add_vec(8'h07, "0");   add_vec(8'h08, ":");  add_vec(8'h09, "0"); add_vec(8'h0B, ":");
        add_vec(8'h0E, " ");   add_vec(8'h10, " ");
        run_lcd_tab();

        // Set 23:58:00 on hold, then run into midnight rollover.
        sw[2] = 1'b1;
        east_to(3'd1);
        press_until(0, 8'h23, 30, "set_hrs_23");
        east_to(3'd2);
        press_until(1, 8'h58, 70, "set_min_58");
        east_to(3'd3); east_to(3'd4); east_to(3'd0);
        sw[2] = 1'b0;
        wait_time(8'h23, 8'h59, 8'h59, 1300, "reach_235959");
        wait_time(8'h00, 8'h00, 8'h00, 15, "rollover_000000");
        sw[0] = 1'b1;
        add_vec(8'h06, 8'h31); add_vec(8'h07, 8'h32); add_vec(8'h0E, 8'h41); add_vec(8'h0F, "M");
        run_lcd_tab();
        sw[0] = 1'b0;

        // Hour edit, glitch rejection, blinking and frozen prescaler.
        east_to(3'd1);
        repeat (3) press(1'b1, 1'b0);
        check8("hrs_after_3", hrs_d, 8'h03);
        btn_south = 1'b1; cyc(2); btn_south = 1'b0; cyc(12);
        check8("hrs_after_glitch", hrs_d, 8'h03);
        lcd_index = 8'h06;
        seen_blank = 0; seen_digit = 0; seen_other = 0;
        for (int k = 0; k < 2 * CLK_HZ; k++) begin
            cyc(1);
            if (lcd_char == 8'h20) seen_blank++;
            else if (lcd_char == 8'h30) seen_digit++;
            else seen_other++;
        end
        check8("blink_seen_blank", 8'(seen_blank > 0), 8'h01);
        check8("blink_seen_digit", 8'(seen_digit > 0), 8'h01);
        check8("blink_other_chars", 8'(seen_other), 8'h00);
        east_to(3'd2);
        press(1'b1, 1'b0);
        cyc(30);
        check8("frozen_sec", sec_d, 8'h00);
        check8("frozen_min", min_d, 8'h01);
        east_to(3'd3); east_to(3'd4); east_to(3'd0);
        lcd_index = 8'h06;
        seen_blank = 0;
        for (int k = 0; k < 2 * CLK_HZ; k++) begin
            cyc(1);
            if (lcd_char != 8'h30) seen_blank++;
        end
        check8("run_no_blink", 8'(seen_blank), 8'h00);

        // Time 00:00:00 and alarm 00:01 on hold, then let the alarm fire.
        sw[2] = 1'b1;
        east_to(3'd1);
        press_until(0, 8'h00, 30, "set_hrs_00");
        east_to(3'd2);
        press_until(1, 8'h00, 70, "set_min_00");
        east_to(3'd3);
        repeat (17) press(1'b1, 1'b0);
        east_to(3'd4);
        press(1'b1, 1'b0);
        east_to(3'd0);
        sw[1] = 1'b1;
        add_vec(8'h40, "A"); add_vec(8'h41, "l"); add_vec(8'h42, "m"); add_vec(8'h43, " ");
        add_vec(8'h44, "0"); add_vec(8'h45, "0"); add_vec(8'h46, ":"); add_vec(8'h47, "0");
        add_vec(8'h48, "1"); add_vec(8'h49, " "); add_vec(8'h4A, "*"); add_vec(8'h4F, "0");
        add_vec(8'h50, " "); add_vec(8'hFF, " "); add_vec(8'h0C, "0"); add_vec(8'h0D, "0");
        run_lcd_tab();
        sw[2] = 1'b0;
        cyc(599);
        check8("alarm_before_match", {7'd0, alarm}, 8'h00);
        check8("sec_before_match", sec_d, 8'h59);
        cyc(1);
        check8("alarm_at_match", {7'd0, alarm}, 8'h01);
        check8("min_at_match", min_d, 8'h01);
        check8("led_alarm", led, 8'h80);
        press(1'b1, 1'b0);
        check8("alarm_ack", {7'd0, alarm}, 8'h00);
        check8("led_after_ack", led, 8'h00);

        // Alarm 00:03; disable in the same cycle as the matching tick.
        sw[2] = 1'b1;
        east_to(3'd1); east_to(3'd2);
        press(1'b1, 1'b0);
        east_to(3'd3); east_to(3'd4);
        press(1'b1, 1'b0); press(1'b1, 1'b0);
        east_to(3'd0);
        sw[2] = 1'b0;
        cyc(599);
        check8("sec_pre_disable", sec_d, 8'h59);
        check8("min_pre_disable", min_d, 8'h02);
        sw[1] = 1'b0;
        cyc(1);
        check8("alarm_disabled_match", {7'd0, alarm}, 8'h00);
        check8("min_disabled_match", min_d, 8'h03);
        press(1'b1, 1'b1);
        check8("state_east_south", {5'd0, led[2:0]}, 8'h01);
        check8("hrs_east_south", hrs_d, 8'h00);

        // Alarm fires while editing alarm minutes, then async reset.
        sw[2] = 1'b1;
        east_to(3'd2);
        press(1'b1, 1'b0);
        east_to(3'd3); east_to(3'd4);
        press(1'b1, 1'b0); press(1'b1, 1'b0);
        sw[1] = 1'b1;
        sw[2] = 1'b0;
        cyc(600);
        check8("alarm_in_set_amin", {7'd0, alarm}, 8'h01);
        check8("min_in_set_amin", min_d, 8'h05);
        check8("led_in_set_amin", led, 8'h84);
        #2 rst_n = 1'b0;
        #1;
        check8("async_rst_alarm", {7'd0, alarm}, 8'h00);
        check8("async_rst_led", led, 8'h00);
        check8("async_rst_lcdchar", lcd_char, 8'h00);
        check8("async_rst_min", min_d, 8'h00);
        check8("async_rst_sec", sec_d, 8'h00);
        @(negedge clk);
        lcd_index = 8'h4F;
        rst_n = 1'b1;
        cyc(1);
        check8("lcd[4F]_after_rst", lcd_char, 8'h30);
        add_vec(8'h44, "0"); add_vec(8'h45, "7"); add_vec(8'h47, "0"); add_vec(8'h48, "0");
        run_lcd_tab();
        cyc(4);
        check8("sec_before_tick_after_rst", sec_d, 8'h00);
        cyc(1);
        check8("sec_tick_after_rst", sec_d, 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
